nonlinear_ctrl: RTL and testbench
=================================

NONLINEAR_CTRL -- requirements
Module: nonlinear_ctrl

Interface
REQ-001 Parameter RSA_DW, default 16, word width.
REQ-002 Parameter TB_AW, default 12, temp-buffer address width.
REQ-003 Parameter RD_DELAY, default 3, cycles from TB_ena to valid TB_douta.
REQ-004 Parameter RD_BASE, default 0; WR_BASE, default 16: operand and result base addresses.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 sys_rst  in  1  synchronous reset, active-high.
REQ-007 nonlinear_m_val  in  3  request from PE_config, one-hot stage (001 PRD, 010 NEW, 100 UPD).
REQ-008 nonlinear_m_rdy  in  3  PE_config ready to take completion, per stage.
REQ-009 nonlinear_s_rdy  out  3  block idle and able to accept a request.
REQ-010 nonlinear_s_val  out  3  completion valid, one-hot latched stage.
REQ-011 TB_ena  out  1; TB_addra  out  TB_AW; TB_douta  in  RSA_DW: operand read port.
REQ-012 TB_enb  out  1; TB_web  out  1; TB_addrb  out  TB_AW; TB_dinb  out  RSA_DW: result write port.
REQ-013 op_val  out  1; op_data  out  RSA_DW: operand stream to nonlinear datapath.
REQ-014 res_val  in  1; res_data  in  RSA_DW: result stream from datapath.
REQ-015 nl_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states IDLE, RD, CAL, WR, DONE.
REQ-017 Counts per stage: PRD 3 operands/3 results; NEW 5/2; UPD 5/2.
REQ-018 IDLE: nonlinear_s_rdy=111; request accepted when nonlinear_m_val has exactly one bit set; stage latched; next RD.
REQ-019 Zero or multi-hot nonlinear_m_val in IDLE: ignored, stay IDLE.
REQ-020 RD: TB_ena=1 one cycle per operand, TB_addra=RD_BASE+i, i=0..N-1 consecutive; next CAL after last read issued.
REQ-021 op_val=1 with op_data=TB_douta exactly RD_DELAY cycles after each TB_ena, even after FSM enters CAL.
REQ-022 CAL: each res_val captured into 3-entry result buffer in arrival order; res_val in any state other than RD/CAL, or beyond expected count, discarded.
REQ-023 res_val during RD (early result) is accepted and counted.
REQ-024 CAL->WR on the cycle after the expected result count is reached.
REQ-025 WR: TB_enb=TB_web=1 one result per cycle, TB_addrb=WR_BASE+j, TB_dinb=buffer[j]; next DONE after last write.
REQ-026 DONE: nonlinear_s_val=latched stage, nonlinear_s_rdy=000; exits to IDLE on cycle nonlinear_m_rdy & stage nonzero; nonlinear_s_val drops that same edge.
REQ-027 nonlinear_s_rdy=000 in all states but IDLE; new requests there ignored.
REQ-028 PRD minimum latency, datapath returning immediately: DONE reached no earlier than 3+RD_DELAY+3 cycles after acceptance.
REQ-029 Counters sized for 5 operands; address offsets add without wrap beyond TB_AW.

Reset
REQ-030 sys_rst synchronous; on edge with sys_rst=1: FSM IDLE, counters 0, buffer cleared, read-delay pipeline flushed.
REQ-031 Reset values: nonlinear_s_rdy=000 during reset cycle then 111, nonlinear_s_val=000, TB_ena=TB_enb=TB_web=0, addresses 0, TB_dinb=0, op_val=0, op_data=0, nl_err=0.
REQ-032 Reset mid-operation aborts without completing writes or asserting nonlinear_s_val.

Configuration
REQ-033 Macro NL_TIMEOUT_EN defined: 8-bit watchdog counts CAL cycles; at 255 cycles without completion FSM returns IDLE, nl_err set until sys_rst, no writes, no nonlinear_s_val.
REQ-034 NL_TIMEOUT_EN undefined: CAL waits indefinitely; nl_err tied 0.

Verification
REQ-035 Reset, then m_val=001 one cycle; datapath echoes results 0x0011,0x0022,0x0033 -> reads addr 0,1,2; writes 0x0011@16,0x0022@17,0x0033@18; s_val=001 until m_rdy=001.
REQ-036 m_val=010, TB holds 1..5 at addr 0..4 -> op_data 1,2,3,4,5 at 3-cycle lag; 2 results written at 16,17; s_val=010.
REQ-037 m_val=011 and m_val=000 in IDLE -> no TB_ena, s_rdy stays 111.
REQ-038 m_val=100 asserted again while in CAL -> ignored; single completion; 4 extra res_val pulses in DONE -> no writes.
REQ-039 sys_rst pulsed in WR after first write -> no further writes, s_val=000, s_rdy=111 next cycle.
REQ-040 NL_TIMEOUT_EN defined, res_val never asserted -> IDLE after 255 CAL cycles, nl_err=1, s_val never 1.

Source files
------------

// File: rtl/nonlinear_ctrl_if.sv
// nonlinear_ctrl_if: bundles the PE_config handshake, temp-buffer ports and
// datapath streams of nonlinear_ctrl. The slave modport is the controller's view.
interface nonlinear_ctrl_if #(
   parameter int RSA_DW = 16,
   parameter int TB_AW  = 12
);
   logic [2:0]        nonlinear_m_val;
   logic [2:0]        nonlinear_m_rdy;
   logic [2:0]        nonlinear_s_rdy;
   logic [2:0]        nonlinear_s_val;
   logic              TB_ena;
   logic [TB_AW-1:0]  TB_addra;
   logic [RSA_DW-1:0] TB_douta;
   logic              TB_enb;
   logic              TB_web;
   logic [TB_AW-1:0]  TB_addrb;
   logic [RSA_DW-1:0] TB_dinb;
   logic              op_val;
   logic [RSA_DW-1:0] op_data;
   logic              res_val;
   logic [RSA_DW-1:0] res_data;
   logic              nl_err;

   modport slave (
      input  nonlinear_m_val, nonlinear_m_rdy, TB_douta, res_val, res_data,
      output nonlinear_s_rdy, nonlinear_s_val, TB_ena, TB_addra,
             TB_enb, TB_web, TB_addrb, TB_dinb, op_val, op_data, nl_err
   );

   modport master (
      output nonlinear_m_val, nonlinear_m_rdy, TB_douta, res_val, res_data,
      input  nonlinear_s_rdy, nonlinear_s_val, TB_ena, TB_addra,
             TB_enb, TB_web, TB_addrb, TB_dinb, op_val, op_data, nl_err
   );
endinterface

// File: rtl/nonlinear_ctrl.sv
// nonlinear_ctrl: sequences one nonlinear stage (PRD/NEW/UPD) -- reads operands
// from the temp buffer, streams them to the datapath, collects results and
// writes them back, then holds a completion until PE_config takes it.
// Optional macro NL_TIMEOUT_EN: CAL watchdog with sticky nl_err.
module nonlinear_ctrl #(
   parameter int RSA_DW   = 16,
   parameter int TB_AW    = 12,
   parameter int RD_DELAY = 3,
   parameter int RD_BASE  = 0,
   parameter int WR_BASE  = 16
)(
   input logic             clk,
   input logic             sys_rst,
   nonlinear_ctrl_if.slave bus
);
   localparam logic [TB_AW-1:0] RD_B = TB_AW'(RD_BASE);
   localparam logic [TB_AW-1:0] WR_B = TB_AW'(WR_BASE);

   typedef enum logic [2:0] {IDLE, RD, CAL, WR, DONE} state_t;

   state_t            state;
   logic [2:0]        stage;
   logic [2:0]        rd_cnt;
   logic [1:0]        res_cnt;
   logic [1:0]        wr_cnt;
   logic [RSA_DW-1:0] res_buf [3];
   // bit 0 is the registered TB_ena; bit k marks a read issued k cycles ago
   logic [RD_DELAY:0] vld_pipe;
   logic [2:0]        s_rdy_q, s_val_q;
   logic [TB_AW-1:0]  addra_q, addrb_q;
   logic              enb_q;
   logic [RSA_DW-1:0] dinb_q;
   logic [2:0]        n_ops;
   logic [1:0]        n_res;
   logic              req_ok, res_take;
`ifdef NL_TIMEOUT_EN
   logic [7:0]        wdog;
   logic              err_q;
`endif

   // per-stage operand/result counts; PRD is the only 3/3 stage
   always_comb begin
      n_ops = 3'd3;
      n_res = 2'd3;
      if (stage != 3'b001) begin
         n_ops = 3'd5;
         n_res = 2'd2;
      end
   end

   assign req_ok   = (bus.nonlinear_m_val == 3'b001) || (bus.nonlinear_m_val == 3'b010) ||
                     (bus.nonlinear_m_val == 3'b100);
   // early results during RD count too; surplus or out-of-phase results drop
   assign res_take = bus.res_val && ((state == RD) || (state == CAL)) && (res_cnt < n_res);

   // control FSM, read-delay pipeline and result buffer
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         stage    <= 3'b000;
         rd_cnt   <= 3'd0;
         res_cnt  <= 2'd0;
         wr_cnt   <= 2'd0;
         vld_pipe <= '0;
         s_rdy_q  <= 3'b000;
         s_val_q  <= 3'b000;
         addra_q  <= '0;
         addrb_q  <= '0;
         enb_q    <= 1'b0;
         dinb_q   <= '0;
         for (int k = 0; k < 3; k++) res_buf[k] <= '0;
`ifdef NL_TIMEOUT_EN
         wdog     <= 8'd0;
         err_q    <= 1'b0;
`endif
      end else begin
         vld_pipe <= {vld_pipe[RD_DELAY-1:0], (state == RD)};
         enb_q    <= 1'b0;
         if (res_take) begin
            res_buf[res_cnt] <= bus.res_data;
            res_cnt          <= res_cnt + 2'd1;
         end
         case (state)
            IDLE: begin
               if (req_ok) begin
                  stage   <= bus.nonlinear_m_val;
                  rd_cnt  <= 3'd0;
                  res_cnt <= 2'd0;
                  wr_cnt  <= 2'd0;
                  s_rdy_q <= 3'b000;
                  state   <= RD;
               end else begin
                  s_rdy_q <= 3'b111;
               end
            end
            RD: begin
               addra_q <= RD_B + TB_AW'(rd_cnt);
               rd_cnt  <= rd_cnt + 3'd1;
`ifdef NL_TIMEOUT_EN
               wdog    <= 8'd0;
`endif
               if (rd_cnt == n_ops - 3'd1) state <= CAL;
            end
            CAL: begin
               if (res_cnt == n_res) begin
                  state <= WR;
               end else begin
`ifdef NL_TIMEOUT_EN
                  wdog <= wdog + 8'd1;
                  if (wdog == 8'd254) begin
                     err_q   <= 1'b1;
                     s_rdy_q <= 3'b111;
                     state   <= IDLE;
                  end
`endif
               end
            end
            WR: begin
               enb_q   <= 1'b1;
               addrb_q <= WR_B + TB_AW'(wr_cnt);
               dinb_q  <= res_buf[wr_cnt];
               wr_cnt  <= wr_cnt + 2'd1;
               if (wr_cnt == n_res - 2'd1) begin
                  s_val_q <= stage;
                  state   <= DONE;
               end
            end
            DONE: begin
               if ((bus.nonlinear_m_rdy & stage) != 3'b000) begin
                  s_val_q <= 3'b000;
                  s_rdy_q <= 3'b111;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.nonlinear_s_rdy = s_rdy_q;
   assign bus.nonlinear_s_val = s_val_q;
   assign bus.TB_ena          = vld_pipe[0];
   assign bus.TB_addra        = addra_q;
   assign bus.TB_enb          = enb_q;
   assign bus.TB_web          = enb_q;
   assign bus.TB_addrb        = addrb_q;
   assign bus.TB_dinb         = dinb_q;
   assign bus.op_val          = vld_pipe[RD_DELAY];
   assign bus.op_data         = vld_pipe[RD_DELAY] ? bus.TB_douta : '0;
`ifdef NL_TIMEOUT_EN
   assign bus.nl_err          = err_q;
`else
   assign bus.nl_err          = 1'b0;
`endif
endmodule

// File: tb/tb_nonlinear_ctrl.sv
// tb_nonlinear_ctrl: directed table of stage requests plus hand-written
// sequences for CAL re-requests, late results, mid-write reset and timeout.
module tb_nonlinear_ctrl;
   localparam int DW = 16, AW = 12, RDD = 3;

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 clk = ~clk;

   nonlinear_ctrl_if #(.RSA_DW(DW), .TB_AW(AW)) bus ();
   nonlinear_ctrl #(.RSA_DW(DW), .TB_AW(AW), .RD_DELAY(RDD), .RD_BASE(0), .WR_BASE(16))
      dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));

   // temp-buffer model: read data arrives RDD cycles after TB_ena/TB_addra
   logic [DW-1:0] mem [0:31];
   logic [DW-1:0] dq [0:RDD-1];
   always @(posedge clk) begin
      dq[0] <= mem[bus.TB_addra[4:0]];
      for (int k = 1; k < RDD; k++) dq[k] <= dq[k-1];
   end
   assign bus.TB_douta = dq[RDD-1];

   // datapath model: echo operands immediately, or manual drive
   logic          echo_en = 1'b0;
   logic          man_val = 1'b0;
   logic [DW-1:0] man_data = '0;
   assign bus.res_val  = man_val | (echo_en & bus.op_val);
   assign bus.res_data = man_val ? man_data : bus.op_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_addr[$], rd_cyc[$], op_d[$], op_cyc[$], wr_a[$], wr_d[$];
   bit sval_seen;
   always @(negedge clk) begin
      if (bus.TB_ena) begin rd_addr.push_back(int'(bus.TB_addra)); rd_cyc.push_back(cyc); end
      if (bus.op_val) begin op_d.push_back(int'(bus.op_data)); op_cyc.push_back(cyc); end
      if (bus.TB_enb && bus.TB_web) begin wr_a.push_back(int'(bus.TB_addrb)); wr_d.push_back(int'(bus.TB_dinb)); end
      if (bus.nonlinear_s_val != 3'b000) sval_seen = 1'b1;
   end

   int checks = 0, failures = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr_logs();
      rd_addr.delete(); rd_cyc.delete(); op_d.delete(); op_cyc.delete();
      wr_a.delete(); wr_d.delete(); sval_seen = 1'b0;
   endtask

   task automatic wait_sval(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (bus.nonlinear_s_val != 3'b000) begin ok = 1'b1; break; end
      end
   endtask

   typedef struct {
      logic [2:0]    mval;
      logic [DW-1:0] d [5];
      int            nrd;
      int            nwr;
      logic [DW-1:0] w [3];
   } vec_t;
   vec_t vt [7];

   initial begin
      bit ok;
      int acc, lat, n;
      bus.nonlinear_m_val = 3'b000;
      bus.nonlinear_m_rdy = 3'b000;
      for (int k = 0; k < 32; k++) mem[k] = '0;

      vt[0] = '{mval:3'b001, d:'{16'h0011,16'h0022,16'h0033,16'h0,16'h0}, nrd:3, nwr:3, w:'{16'h0011,16'h0022,16'h0033}};
      vt[1] = '{mval:3'b010, d:'{16'h1,16'h2,16'h3,16'h4,16'h5}, nrd:5, nwr:2, w:'{16'h1,16'h2,16'h0}};
      vt[2] = '{mval:3'b100, d:'{16'h10,16'h20,16'h30,16'h40,16'h50}, nrd:5, nwr:2, w:'{16'h10,16'h20,16'h0}};
      vt[3] = '{mval:3'b011, d:'{16'h7,16'h7,16'h7,16'h7,16'h7}, nrd:0, nwr:0, w:'{16'h0,16'h0,16'h0}};
      vt[4] = '{mval:3'b000, d:'{16'h7,16'h7,16'h7,16'h7,16'h7}, nrd:0, nwr:0, w:'{16'h0,16'h0,16'h0}};
      vt[5] = '{mval:3'b111, d:'{16'h7,16'h7,16'h7,16'h7,16'h7}, nrd:0, nwr:0, w:'{16'h0,16'h0,16'h0}};
      vt[6] = '{mval:3'b110, d:'{16'h7,16'h7,16'h7,16'h7,16'h7}, nrd:0, nwr:0, w:'{16'h0,16'h0,16'h0}};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_rdy", 32'(bus.nonlinear_s_rdy), 0);
      chk("rst_s_val", 32'(bus.nonlinear_s_val), 0);
      chk("rst_ena",   32'(bus.TB_ena), 0);
      chk("rst_enb",   32'(bus.TB_enb), 0);
      chk("rst_web",   32'(bus.TB_web), 0);
      chk("rst_addra", 32'(bus.TB_addra), 0);
      chk("rst_addrb", 32'(bus.TB_addrb), 0);
      chk("rst_dinb",  32'(bus.TB_dinb), 0);
      chk("rst_opval", 32'(bus.op_val), 0);
      chk("rst_opdat", 32'(bus.op_data), 0);
      chk("rst_nlerr", 32'(bus.nl_err), 0);
      sys_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_rdy", 32'(bus.nonlinear_s_rdy), 32'h7);

      // table-driven stage requests
      for (int v = 0; v < 7; v++) begin
         for (int k = 0; k < 5; k++) mem[k] = vt[v].d[k];
         clr_logs();
         echo_en = 1'b1;
         @(posedge clk); #1;
         bus.nonlinear_m_val = vt[v].mval;
         @(posedge clk); #1;
         acc = cyc;
         bus.nonlinear_m_val = 3'b000;
         if (vt[v].nrd == 0) begin
            chk($sformatf("v%0d_s_rdy_hold", v), 32'(bus.nonlinear_s_rdy), 32'h7);
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_no_reads", v), rd_addr.size(), 0);
            chk($sformatf("v%0d_no_sval", v), 32'(sval_seen), 0);
            chk($sformatf("v%0d_s_rdy", v), 32'(bus.nonlinear_s_rdy), 32'h7);
         end else begin
            wait_sval(100, ok);
            chk($sformatf("v%0d_done_reached", v), 32'(ok), 1);
            lat = cyc - acc;
            chk($sformatf("v%0d_latency_ge9", v), 32'(lat >= 9), 1);
            chk($sformatf("v%0d_s_val", v), 32'(bus.nonlinear_s_val), 32'(vt[v].mval));
            chk($sformatf("v%0d_s_rdy_busy", v), 32'(bus.nonlinear_s_rdy), 0);
            bus.nonlinear_m_rdy = ~vt[v].mval;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_s_val_hold", v), 32'(bus.nonlinear_s_val), 32'(vt[v].mval));
            chk($sformatf("v%0d_rd_cnt", v), rd_addr.size(), vt[v].nrd);
            chk($sformatf("v%0d_op_cnt", v), op_d.size(), vt[v].nrd);
            for (int k = 0; k < vt[v].nrd; k++) begin
               chk($sformatf("v%0d_rd_addr%0d", v, k), (k < rd_addr.size()) ? rd_addr[k] : -1, k);
               chk($sformatf("v%0d_op_data%0d", v, k), (k < op_d.size()) ? op_d[k] : -1, 32'(vt[v].d[k]));
               chk($sformatf("v%0d_op_lag%0d", v, k),
                   (k < op_cyc.size() && k < rd_cyc.size()) ? op_cyc[k] - rd_cyc[k] : -1, RDD);
            end
            chk($sformatf("v%0d_wr_cnt", v), wr_a.size(), vt[v].nwr);
            for (int j = 0; j < vt[v].nwr; j++) begin
               chk($sformatf("v%0d_wr_addr%0d", v, j), (j < wr_a.size()) ? wr_a[j] : -1, 16 + j);
               chk($sformatf("v%0d_wr_data%0d", v, j), (j < wr_d.size()) ? wr_d[j] : -1, 32'(vt[v].w[j]));
            end
            bus.nonlinear_m_rdy = vt[v].mval;
            @(negedge clk);
            bus.nonlinear_m_rdy = 3'b000;
            chk($sformatf("v%0d_s_val_drop", v), 32'(bus.nonlinear_s_val), 0);
            chk($sformatf("v%0d_s_rdy_back", v), 32'(bus.nonlinear_s_rdy), 32'h7);
         end
      end

      // UPD: request re-asserted in CAL, manual results, late results in DONE
      clr_logs();
      echo_en = 1'b0;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b100;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b000;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.TB_ena && bus.TB_addra == 12'd4) begin ok = 1'b1; break; end
      end
      chk("upd_last_read", 32'(ok), 1);
      bus.nonlinear_m_val = 3'b100;
      repeat (5) @(negedge clk);
      chk("upd_cal_s_rdy", 32'(bus.nonlinear_s_rdy), 0);
      bus.nonlinear_m_val = 3'b000;
      man_val = 1'b1; man_data = 16'h00A1;
      @(negedge clk);
      man_data = 16'h00A2;
      @(negedge clk);
      man_val = 1'b0;
      wait_sval(50, ok);
      chk("upd_done_reached", 32'(ok), 1);
      chk("upd_s_val", 32'(bus.nonlinear_s_val), 32'h4);
      man_val = 1'b1; man_data = 16'h00EE;
      repeat (4) @(negedge clk);
      man_val = 1'b0;
      repeat (2) @(negedge clk);
      chk("upd_wr_cnt", wr_a.size(), 2);
      chk("upd_wr_d0", (wr_d.size() > 0) ? wr_d[0] : -1, 32'h00A1);
      chk("upd_wr_d1", (wr_d.size() > 1) ? wr_d[1] : -1, 32'h00A2);
      chk("upd_wr_a1", (wr_a.size() > 1) ? wr_a[1] : -1, 17);
      bus.nonlinear_m_rdy = 3'b100;
      @(negedge clk);
      bus.nonlinear_m_rdy = 3'b000;
      sval_seen = 1'b0;
      repeat (20) @(negedge clk);
      chk("upd_single_rd", rd_addr.size(), 5);
      chk("upd_single_done", 32'(sval_seen), 0);
      chk("upd_wr_after", wr_a.size(), 2);

      // PRD with reset pulsed right after the first write
      for (int k = 0; k < 3; k++) mem[k] = vt[0].d[k];
      clr_logs();
      echo_en = 1'b1;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b001;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b000;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.TB_enb) begin ok = 1'b1; break; end
      end
      chk("rstwr_first_write", 32'(ok), 1);
      sys_rst = 1'b1;
      @(negedge clk);
      sys_rst = 1'b0;
      chk("rstwr_s_rdy_rst", 32'(bus.nonlinear_s_rdy), 0);
      chk("rstwr_enb_rst", 32'(bus.TB_enb), 0);
      @(negedge clk);
      chk("rstwr_s_rdy", 32'(bus.nonlinear_s_rdy), 32'h7);
      chk("rstwr_s_val", 32'(bus.nonlinear_s_val), 0);
      repeat (10) @(negedge clk);
      chk("rstwr_wr_cnt", wr_a.size(), 1);
      chk("rstwr_no_sval", 32'(sval_seen), 0);

`ifdef NL_TIMEOUT_EN
      // PRD with a silent datapath: watchdog abort
      clr_logs();
      echo_en = 1'b0;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b001;
      @(negedge clk);
      bus.nonlinear_m_val = 3'b000;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.TB_ena && bus.TB_addra == 12'd2) begin ok = 1'b1; break; end
      end
      chk("to_last_read", 32'(ok), 1);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n++;
         if (bus.nonlinear_s_rdy == 3'b111) begin ok = 1'b1; break; end
      end
      chk("to_idle", 32'(ok), 1);
      chk("to_cal_cycles", n, 255);
      chk("to_nl_err", 32'(bus.nl_err), 1);
      chk("to_no_sval", 32'(sval_seen), 0);
      chk("to_no_writes", wr_a.size(), 0);
`else
      chk("nl_err_tied", 32'(bus.nl_err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
